// File: rtl/param_mc_pkg.sv
// param_mc_pkg: shared definitions for the param_mc_core CPU slice.
//   - opcode constants OP_NOP .. OP_HALT
//   - FSM state encoding state_t (S_FETCH .. S_HALT)
//   - instruction field-slice helpers. Any instruction up to WORD_MAX_W bits
//     is handled by passing REG_AW / IMM_W as arguments.
//   - opcode classification helpers (writes register, updates Z)
package param_mc_pkg;

    localparam int WORD_MAX_W = 64;
    typedef logic [WORD_MAX_W-1:0] word_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_MOVI = 4'h6;
    localparam logic [3:0] OP_SHL  = 4'h7;
    localparam logic [3:0] OP_SHR  = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    // Instruction layout, MSB first: {op[3:0], rd, rs, imm}
    function automatic word_t field_mask(input int width);
        return (word_t'(1) << width) - word_t'(1);
    endfunction

    function automatic logic [3:0] f_op(input word_t w, input int reg_aw, input int imm_w);
        return 4'(w >> (2*reg_aw + imm_w));
    endfunction

    function automatic word_t f_rd(input word_t w, input int reg_aw, input int imm_w);
        return (w >> (reg_aw + imm_w)) & field_mask(reg_aw);
    endfunction

    function automatic word_t f_rs(input word_t w, input int reg_aw, input int imm_w);
        return (w >> imm_w) & field_mask(reg_aw);
    endfunction

    function automatic word_t f_imm(input word_t w, input int imm_w);
        return w & field_mask(imm_w);
    endfunction

    // Ops 1..8 write rd at WB
    function automatic logic op_writes(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_SHR);
    endfunction

    // Z is updated by the arithmetic/logic/shift ops, not by MOVI
    function automatic logic op_sets_z(input logic [3:0] op);
        return op_writes(op) && (op != OP_MOVI);
    endfunction

endpackage

// File: rtl/param_mc_if.sv
// param_mc_if: instruction fetch port of param_mc_core.
//   instr_addr  fetch address (core drives, equals PC)
//   instr_in    instruction word for instr_addr
//   instr_valid instr_in is valid this cycle
// modport master: the core; modport slave: the instruction memory / bench.
interface param_mc_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
);
    logic [PC_W-1:0]    instr_addr;
    logic [INSTR_W-1:0] instr_in;
    logic               instr_valid;

    modport master (
        output instr_addr,
        input  instr_in,
        input  instr_valid
    );

    modport slave (
        input  instr_addr,
        output instr_in,
        output instr_valid
    );
endinterface

// File: rtl/mc_regfile.sv
// mc_regfile: NREG x DATA_W register file (NREG = 2**REG_AW).
//   CLK, RST      clock, synchronous active-high clear of every entry
//   we, wa, wd    synchronous write port
//   ra_a / rd_a   asynchronous read port A
//   ra_b / rd_b   asynchronous read port B
// reg[0] is an ordinary register. RST takes priority over a write.
module mc_regfile #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [REG_AW-1:0] ra_a,
    input  logic [REG_AW-1:0] ra_b,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b
);
    localparam int NREG = 1 << REG_AW;

    logic [DATA_W-1:0] mem [NREG];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

    assign rd_a = mem[ra_a];
    assign rd_b = mem[ra_b];

endmodule

// File: rtl/param_mc_core.sv
// param_mc_core: parametrised multi-cycle register-file CPU core.
// FETCH/DECODE/EXEC/WB FSM over an NREG-entry register file.
//   CLK, RST     clock, synchronous active-high reset
//   bus          instruction fetch port (param_mc_if.master)
//   rs, rd       source / destination index of the current IR
//   rs_data      A operand latched in DECODE
//   rd_data      B operand latched in DECODE
//   alu_out      registered ALU result (held until the next EXEC of a writing op)
//   PC           program counter
//   zero, carry  Z / C flags
//   halted       core is in HALT
// Build option: define BRANCH_EN to build BEQ (op 9) and JMP (op A);
// without it both decode as NOP and no compare logic is generated.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_FETCH  | wait for instr_valid, latch IR
// S_DECODE | latch rs_data/rd_data from the register file
// S_EXEC   | register ALU result and flags, evaluate branch
// S_WB     | write rd, advance PC (or enter HALT for op F)
// S_HALT   | sticky until RST, PC frozen, no fetch
module param_mc_core
    import param_mc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8,
    parameter int REG_AW = 2,
    parameter int IMM_W  = 8
) (
    input  logic              CLK,
    input  logic              RST,
    param_mc_if.master        bus,
    output logic [REG_AW-1:0] rs,
    output logic [REG_AW-1:0] rd,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] alu_out,
    output logic [PC_W-1:0]   PC,
    output logic              zero,
    output logic              carry,
    output logic              halted
);
    localparam int INSTR_W = 4 + 2*REG_AW + IMM_W;

    state_t             state;
    logic [INSTR_W-1:0] ir;
    logic [3:0]         op;
    logic [IMM_W-1:0]   imm;

    logic [DATA_W-1:0]  rf_a;
    logic [DATA_W-1:0]  rf_b;
    logic               rf_we;

    logic [DATA_W:0]    sum;
    logic [DATA_W:0]    diff;
    logic [DATA_W-1:0]  alu_res;
    logic               alu_c;

    assign op  = f_op(word_t'(ir), REG_AW, IMM_W);
    assign rd  = REG_AW'(f_rd(word_t'(ir), REG_AW, IMM_W));
    assign rs  = REG_AW'(f_rs(word_t'(ir), REG_AW, IMM_W));
    assign imm = IMM_W'(f_imm(word_t'(ir), IMM_W));

    assign bus.instr_addr = PC;

    // alu_out already holds the result computed in EXEC, so WB writes it directly
    assign rf_we = (state == S_WB) && op_writes(op);

    mc_regfile #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_regfile (
        .CLK  (CLK),
        .RST  (RST),
        .we   (rf_we),
        .wa   (rd),
        .wd   (alu_out),
        .ra_a (rs),
        .ra_b (rd),
        .rd_a (rf_a),
        .rd_b (rf_b)
    );

    // ALU on the latched operands: A = rs_data, B = rd_data
    always_comb begin
        sum     = {1'b0, rd_data} + {1'b0, rs_data};
        // top bit of the (DATA_W+1)-bit difference is the unsigned borrow
        diff    = {1'b0, rd_data} - {1'b0, rs_data};
        alu_res = alu_out;
        alu_c   = carry;
        case (op)
            OP_ADD:  {alu_c, alu_res} = sum;
            OP_SUB:  {alu_c, alu_res} = diff;
            OP_AND:  alu_res = rd_data & rs_data;
            OP_OR:   alu_res = rd_data | rs_data;
            OP_XOR:  alu_res = rd_data ^ rs_data;
            OP_MOVI: alu_res = DATA_W'(imm);
            OP_SHL: begin
                alu_res = {rd_data[DATA_W-2:0], 1'b0};
                alu_c   = rd_data[DATA_W-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, rd_data[DATA_W-1:1]};
                alu_c   = rd_data[0];
            end
            default: ;
        endcase
    end

`ifdef BRANCH_EN
    logic br_taken;
    logic br_cond;

    always_comb begin
        br_cond = (op == OP_JMP) || ((op == OP_BEQ) && (rd_data == rs_data));
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_FETCH;
            PC      <= '0;
            ir      <= '0;
            rs_data <= '0;
            rd_data <= '0;
            alu_out <= '0;
            zero    <= 1'b0;
            carry   <= 1'b0;
            halted  <= 1'b0;
`ifdef BRANCH_EN
            br_taken <= 1'b0;
`endif
        end else begin
            case (state)
                S_FETCH: begin
                    if (bus.instr_valid) begin
                        ir    <= bus.instr_in;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    rs_data <= rf_a;
                    rd_data <= rf_b;
                    state   <= S_EXEC;
                end
                S_EXEC: begin
                    if (op_writes(op)) begin
                        alu_out <= alu_res;
                        carry   <= alu_c;
                    end
                    if (op_sets_z(op)) begin
                        zero <= (alu_res == '0);
                    end
`ifdef BRANCH_EN
                    br_taken <= br_cond;
`endif
                    state <= S_WB;
                end
                S_WB: begin
                    if (op == OP_HALT) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
`ifdef BRANCH_EN
                        PC <= br_taken ? PC_W'(f_imm(word_t'(ir), IMM_W)) : PC + 1'b1;
`else
                        PC <= PC + 1'b1;
`endif
                        state <= S_FETCH;
                    end
                end
                S_HALT: begin
                    halted <= 1'b1;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule
